matrix_result_drain: RTL

Consumer for the row-write port of `matrixMult`. It captures the BATCH_SIZE result rows written via `outputWrEn`/`outputAddr`/`outputData` into a local row buffer. Once every row has been written, it drains the complete M×O result matrix one element per handshake over a valid/ready stream toward the host or DMA side. It is the reader end of the engine's output write interface.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_result_drain_if.sv | 28 ++
 rtl/result_row_buffer.sv | 22 ++
 rtl/matrix_result_drain.sv | 97 +++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the matrix-engine side blocks: result geometry, FSM state encodings
// and the element-slice helper used to pick one element out of a packed row.
package matrix_pkg;
  localparam int BATCH_SIZE          = 8;
  localparam int LOG_BATCH_SIZE      = 3;
  localparam int OUTPUT_FEATURES     = 8;
  localparam int LOG_OUTPUT_FEATURES = 3;
  localparam int OUTPUT_WIDTH        = 16;
  localparam int ROW_WIDTH           = OUTPUT_FEATURES * OUTPUT_WIDTH;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef logic [ROW_WIDTH-1:0]           row_t;
  typedef logic [OUTPUT_WIDTH-1:0]        elem_t;
  typedef logic [LOG_BATCH_SIZE-1:0]      row_idx_t;
  typedef logic [LOG_OUTPUT_FEATURES-1:0] col_idx_t;

  // Column 0 sits in the LSBs of a packed row.
  function automatic int elem_lsb(input col_idx_t idx);
    return int'(idx) * OUTPUT_WIDTH;
  endfunction
endpackage

// File: rtl/matrix_result_drain_if.sv
// Row-write port from the engine plus the element stream toward the host/DMA side.
// The drain block is the slave; the engine/host side is the master.
interface matrix_result_drain_if;
  import matrix_pkg::*;

  logic     wrEn;
  row_idx_t wrAddr;
  row_t     wrData;
  logic     outValid;
  logic     outReady;
  elem_t    outData;
  row_idx_t outRow;
  col_idx_t outCol;
  logic     outLast;
  logic     busy;
  logic     done;
  logic     overrun;

  modport master (
    output wrEn, wrAddr, wrData, outReady,
    input  outValid, outData, outRow, outCol, outLast, busy, done, overrun
  );

  modport slave (
    input  wrEn, wrAddr, wrData, outReady,
    output outValid, outData, outRow, outCol, outLast, busy, done, overrun
  );
endinterface

// File: rtl/result_row_buffer.sv
// BATCH_SIZE x row register array: one synchronous write port, combinational row read.
// Contents are deliberately not reset; every row is rewritten before it is drained.
module result_row_buffer
  import matrix_pkg::*;
(
  input  logic     clk,
  input  logic     i_wr_en,
  input  row_idx_t i_wr_addr,
  input  row_t     i_wr_data,
  input  row_idx_t i_rd_addr,
  output row_t     o_rd_data
);
  row_t r_mem [BATCH_SIZE];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/matrix_result_drain.sv
// Captures engine result rows, then streams the full M x O matrix row-major, one element
// per valid/ready handshake; writes arriving while draining are dropped and flagged.
module matrix_result_drain
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  matrix_result_drain_if.slave bus
);
  localparam row_idx_t LAST_ROW = row_idx_t'(BATCH_SIZE - 1);
  localparam col_idx_t LAST_COL = col_idx_t'(OUTPUT_FEATURES - 1);

  state_e                r_state;
  logic [BATCH_SIZE-1:0] r_written;
  row_idx_t              r_row;
  col_idx_t              r_col;
  logic                  r_done;
  logic                  r_overrun;

  logic                  w_drain;
  logic                  w_last;
  logic                  w_wr_fill;
  logic [BATCH_SIZE-1:0] w_written_nxt;
  row_t                  w_rd_row;

  assign w_drain   = (r_state == DRAIN);
  assign w_last    = w_drain && (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_wr_fill = bus.wrEn && !w_drain;

  // Includes this cycle's write so the last row written launches the drain immediately.
  always_comb begin
    w_written_nxt = r_written;
    if (w_wr_fill) begin
      w_written_nxt[bus.wrAddr] = 1'b1;
    end
  end

  result_row_buffer u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_fill),
    .i_wr_addr (bus.wrAddr),
    .i_wr_data (bus.wrData),
    .i_rd_addr (r_row),
    .o_rd_data (w_rd_row)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FILL;
      r_written <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.wrEn && w_drain) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        FILL: begin
          r_written <= w_written_nxt;
          if (&w_written_nxt) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.outReady) begin
            if (w_last) begin
              r_state   <= FILL;
              r_written <= '0;
              r_row     <= '0;
              r_col     <= '0;
              r_done    <= 1'b1;
            end else if (r_col == LAST_COL) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  // Stream fields are gated to zero whenever no element is offered.
  assign bus.outValid = w_drain;
  assign bus.outData  = w_drain ? w_rd_row[elem_lsb(r_col) +: OUTPUT_WIDTH] : '0;
  assign bus.outRow   = w_drain ? r_row : '0;
  assign bus.outCol   = w_drain ? r_col : '0;
  assign bus.outLast  = w_last;
  assign bus.busy     = w_drain;
  assign bus.done     = r_done;
  assign bus.overrun  = r_overrun;
endmodule
